// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, FSM state type and overflow helper for
// cpu_core_param and its register file.
package cpu_pkg;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_SUBI = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;
    localparam logic [2:0] OP_DPL  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_CLEAR,
        S_SHOW
    } cpu_state_t;

    // Signed overflow of a + b from the operand and sum sign bits.
    // Subtraction passes the inverted sign of the subtrahend.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                     input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: REG_N x DATA_W register file, two synchronous read ports
// (one-cycle latency, gated by re) and one write port. Contents are not
// reset.
//   clk              clock
//   re               read enable (both ports)
//   raddr_a/raddr_b  read addresses, rdata_a/rdata_b valid the next cycle
//   we/waddr/wdata   write port
module cpu_regfile #(
    parameter int DATA_W = 16,
    parameter int REG_N  = 16,
    localparam int AW    = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              re,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem [REG_N];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) begin
            rdata_a <= mem[raddr_a];
            rdata_b <= mem[raddr_b];
        end
    end

endmodule

// File: rtl/cpu_core_param.sv
// cpu_core_param: multi-cycle core. One instruction is captured from the
// switches per exec press, operands come from cpu_regfile, the result is
// written back and handed to the LCD driver over disp_req/disp_ack.
//   clk, rst                  clock, async active-high reset
//   op, d1, r2, imm_r3        instruction switches
//   btn_exec_n, btn_show_n    raw active-low buttons
//   busy, result, result_valid, ovf   status
//   disp_req/ack/addr/data    display handshake
module cpu_core_param
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_N  = 16,
    parameter int IMM_W  = 7,
    localparam int AW    = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        op,
    input  logic [AW-1:0]     d1,
    input  logic [AW-1:0]     r2,
    input  logic [IMM_W-1:0]  imm_r3,
    input  logic              btn_exec_n,
    input  logic              btn_show_n,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              ovf,
    output logic              disp_req,
    input  logic              disp_ack,
    output logic [AW-1:0]     disp_addr,
    output logic [DATA_W-1:0] disp_data
);

    // Button synchronisers; a falling edge of the synchronised level
    // becomes a one-cycle pulse.
    logic [1:0] exec_sync, show_sync;
    logic       exec_prev, show_prev;
    logic       exec_pulse, show_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_sync <= '1;
            show_sync <= '1;
            exec_prev <= 1'b1;
            show_prev <= 1'b1;
        end else begin
            exec_sync <= {exec_sync[0], btn_exec_n};
            show_sync <= {show_sync[0], btn_show_n};
            exec_prev <= exec_sync[1];
            show_prev <= show_sync[1];
        end
    end

    assign exec_pulse = exec_prev & ~exec_sync[1];
    assign show_pulse = show_prev & ~show_sync[1];

    cpu_state_t        state;
    logic [2:0]        op_q;
    logic [AW-1:0]     d1_q, r2_q, clr_cnt;
    logic [IMM_W-1:0]  imm_q;

    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // DPL reads R[d1] through port A; the ALU then passes it through.
    assign rf_we    = (state == S_WB) || (state == S_CLEAR);
    assign rf_waddr = (state == S_CLEAR) ? clr_cnt : d1_q;
    assign rf_wdata = (state == S_CLEAR) ? '0 : result;

    cpu_regfile #(.DATA_W(DATA_W), .REG_N(REG_N)) u_rf (
        .clk     (clk),
        .re      (state == S_READ),
        .raddr_a ((op_q == OP_DPL) ? d1_q : r2_q),
        .raddr_b (imm_q[IMM_W-1 -: AW]),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

    // ALU
    logic [DATA_W-1:0]   sext, opb, alu_res;
    logic [DATA_W-1:0]   sum, diff;
    logic [2*DATA_W-1:0] a_ext, b_ext, prod;
    logic                alu_ovf;

    always_comb begin
        sext    = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
        opb     = (op_q == OP_ADDI || op_q == OP_SUBI) ? sext : rdata_b;
        sum     = rdata_a + opb;
        diff    = rdata_a - opb;
        // Low 2*DATA_W bits of the unsigned product of sign-extended
        // operands equal the full signed product.
        a_ext   = {{DATA_W{rdata_a[DATA_W-1]}}, rdata_a};
        b_ext   = {{DATA_W{opb[DATA_W-1]}}, opb};
        prod    = a_ext * b_ext;
        alu_res = rdata_a;
        alu_ovf = ovf;
        case (op_q)
            OP_LOAD: begin
                alu_res = sext;
                alu_ovf = 1'b0;
            end
            OP_ADD, OP_ADDI: begin
                alu_res = sum;
                alu_ovf = add_ovf(rdata_a[DATA_W-1], opb[DATA_W-1], sum[DATA_W-1]);
            end
            OP_SUB, OP_SUBI: begin
                alu_res = diff;
                alu_ovf = add_ovf(rdata_a[DATA_W-1], ~opb[DATA_W-1], diff[DATA_W-1]);
            end
            OP_MUL: begin
                alu_res = prod[DATA_W-1:0];
                alu_ovf = prod != {{DATA_W{prod[DATA_W-1]}}, prod[DATA_W-1:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            ovf          <= 1'b0;
            disp_req     <= 1'b0;
            disp_addr    <= '0;
            disp_data    <= '0;
            clr_cnt      <= '0;
            op_q         <= OP_LOAD;
            d1_q         <= '0;
            r2_q         <= '0;
            imm_q        <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (exec_pulse) begin
                        op_q  <= op;
                        d1_q  <= d1;
                        r2_q  <= r2;
                        imm_q <= imm_r3;
                        busy  <= 1'b1;
                        if (op == OP_CLR) begin
                            state <= S_CLEAR;
                            ovf   <= 1'b0;
                        end else begin
                            state <= S_READ;
                        end
                    end else if (show_pulse) begin
                        op_q  <= OP_DPL;
                        d1_q  <= d1;
                        busy  <= 1'b1;
                        state <= S_READ;
                    end
                end
                S_READ: state <= S_EXEC;
                S_EXEC: begin
                    result <= alu_res;
                    ovf    <= alu_ovf;
                    if (op_q == OP_DPL) begin
                        state     <= S_SHOW;
                        disp_req  <= 1'b1;
                        disp_addr <= d1_q;
                        disp_data <= alu_res;
                    end else begin
                        state        <= S_WB;
                        result_valid <= 1'b1;
                    end
                end
                S_WB: begin
                    state     <= S_SHOW;
                    disp_req  <= 1'b1;
                    disp_addr <= d1_q;
                    disp_data <= result;
                end
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    // Arm the pulse one edge early so it lines up with the
                    // last register write.
                    if (clr_cnt == AW'(REG_N-2)) begin
                        result_valid <= 1'b1;
                        result       <= '0;
                    end
                    if (clr_cnt == AW'(REG_N-1)) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        clr_cnt <= '0;
                    end
                end
                S_SHOW: begin
                    if (disp_ack) begin
                        disp_req <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu_core_param.md
# cpu_core_param

Parametrised successor to the switch-driven CPU top: a multi-cycle core that captures one instruction from the board switches per `btn_exec` press and reads operands from an internal synchronous-read register file. It executes one of eight operations, writes the result back, and hands the written value to the LCD driver over a req/ack handshake. It sits between the switch/button pins and the LCD controller, and replaces the unclocked op/register wiring of the previous top.

## Interface

**Parameters**
- `DATA_W`, 16: register and ALU width.
- `REG_N`, 16: register count; `AW = $clog2(REG_N)`.
- `IMM_W`, 7: immediate field width; must be ≥ `AW`.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `op` in 3: opcode switches.
- `d1` in `AW`: destination register address.
- `r2` in `AW`: source register 2 address.
- `imm_r3` in `IMM_W`: immediate value, or source register 3 address in `imm_r3[IMM_W-1 -: AW]`.
- `btn_exec_n` in 1: raw, active-low execute button.
- `btn_show_n` in 1: raw, active-low show button.
- `busy` out 1: high in every state other than IDLE.
- `result` out `DATA_W`: last computed value.
- `result_valid` out 1: one-cycle pulse on write-back.
- `ovf` out 1: signed overflow of the last ADD/ADDI/SUB/SUBI/MUL.
- `disp_req` out 1: display request; held high until acknowledged.
- `disp_ack` in 1: acknowledge from the LCD driver.
- `disp_addr` out `AW`: register index being displayed.
- `disp_data` out `DATA_W`: value being displayed.

## Operation

**Button inputs**
- Each button passes through a 2-flop synchroniser, then a falling-edge detector producing a one-cycle pulse.
- Synchroniser flops reset to 1.

**State machine** (states in order: IDLE, READ, EXEC, WB, CLEAR, SHOW)
- IDLE
  - On an `exec` pulse: latch `op`, `d1`, `r2` and `imm_r3`, then go to READ.
  - On an `op` of CLR: go to CLEAR instead.
  - On a `show` pulse: latch `d1` and go to READ with an internal DPL op.
  - If both pulses arrive in the same cycle, `exec` wins and `show` is dropped.
- READ: drive the register file read addresses from the latched fields, then go to EXEC.
- EXEC: register-file outputs are valid; compute into `result` and `ovf`. For DPL, skip write-back and go to SHOW; otherwise go to WB.
- WB: write `result` to `R[d1]`, pulse `result_valid`, then go to SHOW.
- CLEAR: a counter runs from 0 to `REG_N-1` and writes 0 to one register per cycle. On the last write, pulse `result_valid`, set `result` to 0, and go to IDLE.
- SHOW
  - `disp_req` is 1, `disp_addr` is `d1`, `disp_data` is `result`.
  - `disp_addr` and `disp_data` are stable while `disp_req` is high.
  - Go to IDLE in the cycle `disp_ack` is sampled high; `disp_req` drops on that edge.
- Button pulses outside IDLE are dropped, not queued.

**Opcodes** (sext = sign-extension of `imm_r3` to `DATA_W`; R3 = `R[imm_r3[IMM_W-1 -: AW]]`)
- 000 LOAD: `R[d1] = sext(imm_r3)`.
- 001 ADD: `R[d1] = R[r2] + R3`.
- 010 ADDI: `R[d1] = R[r2] + sext`.
- 011 SUB: `R[d1] = R[r2] - R3`.
- 100 SUBI: `R[d1] = R[r2] - sext`.
- 101 MUL: `R[d1]` is the low `DATA_W` bits of the signed product. `ovf` is set when the full product is not representable in `DATA_W` signed bits.
- 110 CLR: clears all registers.
- 111 DPL: displays `R[d1]`; no write.

**Arithmetic rules**
- All arithmetic is two's complement and wraps modulo 2^`DATA_W`.
- `ovf` updates in EXEC for ADD/ADDI/SUB/SUBI/MUL only. It is cleared by LOAD and CLR, and left unchanged by DPL.

**Register file**
- Contents are not reset; software issues CLR after reset.
- A read and a write never occur in the same cycle, so no bypass is needed.

## Timing

- **Reset values:** state IDLE, `busy` 0, `result` 0, `result_valid` 0, `ovf` 0, `disp_req` 0, `disp_addr` 0, `disp_data` 0, clear counter 0.
- **Button latency:** a synchronised falling edge seen at edge t gives a pulse in cycle t.
- **ALU ops** (pulse at t):
  - READ at t+1, EXEC at t+2, WB at t+3 with `result_valid` high, SHOW at t+4 with `disp_req` high.
  - `busy` rises at t+1.
  - With `disp_ack` tied high, IDLE is reached at t+5.
- **DPL:** SHOW at t+3.
- **CLR:** CLEAR occupies `REG_N` cycles starting at t+1; IDLE at t+1+`REG_N`.
- **Reset mid-operation:** asynchronous return to the reset values. A write in flight is abandoned, and a CLEAR in progress leaves the register file partially cleared.
- **Late acknowledge:** `disp_ack` high outside SHOW is ignored.

## Structure

- **`cpu_pkg`:** opcode localparams (OP_LOAD through OP_DPL) and the state enum `cpu_state_t`.
- **`cpu_regfile` sub-module:** parameters `DATA_W` and `REG_N`. It has two synchronous read ports with one-cycle latency and one write port, and replaces `ram16_16` in this core.
- **Inline in the core:** synchroniser/edge detect, FSM, and ALU.

## Test plan

1. **Reset, then CLR:** `busy` is high for exactly 16 cycles, `result_valid` pulses once, and a subsequent DPL of R5 shows `disp_data` = 0.
2. **LOAD then ADDI:**
   - LOAD R1 with imm 7'h7F (-1): shows `disp_data` 16'hFFFF.
   - ADDI R2 = R1 + 7'h02: `result` 1, `ovf` 0.
3. **Signed overflow on ADD:**
   - Build R3 = 0x7FFF using LOAD/ADDI/MUL.
   - ADD R4 = R3 + R3: `result` 16'hFFFE, `ovf` 1.
4. **MUL overflow:** R1 = 0x0100, MUL R2 = R1 × R1 gives `result` 0 and `ovf` 1.
5. **Handshake:** hold `disp_ack` low for 10 cycles in SHOW.
   - `disp_req`, `disp_addr` and `disp_data` stay stable throughout.
   - An `exec` press during SHOW is dropped.
   - After the ack, the core is in IDLE.
6. **Reset mid-CLEAR:** assert `rst` at cycle 5 of CLEAR; all outputs return to their reset values on the next sample.
